// File: rtl/program_loader_pkg.sv
// Shared types and sizes for the program loader: FSM states, bus widths,
// and the header range check.
package program_loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int INSTR_W   = 16;
  localparam int PM_ADDR_W = 5;
  localparam int PM_DEPTH  = 32;
  // Count register must hold N = PM_DEPTH, one bit wider than an address.
  localparam int CNT_W     = PM_ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_e;

  // A header is usable when it names between 1 and PM_DEPTH instructions.
  function automatic logic header_ok(input logic [BYTE_W-1:0] hdr);
    return (hdr != 8'd0) && (hdr <= 8'(PM_DEPTH));
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake from the host plus the instruction memory write port.
interface program_loader_if;
  import program_loader_pkg::*;

  logic                 byte_valid;
  logic [BYTE_W-1:0]    byte_data;
  logic                 byte_ready;
  logic                 pm_we;
  logic [PM_ADDR_W-1:0] pm_addr;
  logic [INSTR_W-1:0]   pm_wdata;

  // Host / memory side: supplies bytes, observes the write port.
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, pm_we, pm_addr, pm_wdata
  );

  // Loader side: consumes bytes, drives the write port.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, pm_we, pm_addr, pm_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: parses a framed byte stream (count, instruction bytes,
// XOR checksum), writes instructions into program memory and keeps the CPU
// held in reset until a verified image is present.
module program_loader
  import program_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus,
  input  logic             load_req,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_error
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PM_ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0]    csum_q, csum_d;
  logic [BYTE_W-1:0]    hi_q, hi_d;
  logic [PM_ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [INSTR_W-1:0]   pm_wdata_q, pm_wdata_d;
  logic                 byte_ready_q, byte_ready_d;
  logic                 pm_we_q, pm_we_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 load_done_q, load_done_d;
  logic                 load_error_q, load_error_d;
  logic                 xfer_s;
  logic                 last_s;

  assign xfer_s = bus.byte_valid && byte_ready_q;
  assign last_s = ({1'b0, addr_q} == (count_q - 6'd1));

  // Next-state, datapath updates, and the output decode of the next state.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    csum_d     = csum_q;
    hi_d       = hi_q;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;

    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          if (header_ok(bus.byte_data)) begin
            count_d = CNT_W'(bus.byte_data);
            addr_d  = 5'd0;
            csum_d  = bus.byte_data;
            state_d = HI;
          end else begin
            state_d = ERROR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HI: begin
        if (xfer_s) begin
          hi_d    = bus.byte_data;
          csum_d  = csum_q ^ bus.byte_data;
          state_d = LO;
        end else begin
          state_d = HI;
        end
      end
      LO: begin
        if (xfer_s) begin
          csum_d     = csum_q ^ bus.byte_data;
          pm_addr_d  = addr_q;
          pm_wdata_d = {hi_q, bus.byte_data};
          state_d    = WRITE;
        end else begin
          state_d = LO;
        end
      end
      WRITE: begin
        if (last_s) begin
          state_d = CHECK;
        end else begin
          addr_d  = addr_q + 5'd1;
          state_d = HI;
        end
      end
      CHECK: begin
        if (xfer_s) begin
          state_d = (bus.byte_data == csum_q) ? DONE : ERROR;
        end else begin
          state_d = CHECK;
        end
      end
      DONE: begin
        if (load_req) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      ERROR: begin
        if (load_req) begin
          state_d = IDLE;
        end else begin
          state_d = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered.
    byte_ready_d = (state_d == IDLE) || (state_d == HI) ||
                   (state_d == LO)   || (state_d == CHECK);
    pm_we_d      = (state_d == WRITE);
    cpu_hold_d   = (state_d != DONE);
    load_done_d  = (state_d == DONE);
    load_error_d = (state_d == ERROR);
  end

  // State, datapath and registered outputs; async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= 6'd0;
      addr_q       <= 5'd0;
      csum_q       <= 8'd0;
      hi_q         <= 8'd0;
      pm_addr_q    <= 5'd0;
      pm_wdata_q   <= 16'd0;
      byte_ready_q <= 1'b1;
      pm_we_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      csum_q       <= csum_d;
      hi_q         <= hi_d;
      pm_addr_q    <= pm_addr_d;
      pm_wdata_q   <= pm_wdata_d;
      byte_ready_q <= byte_ready_d;
      pm_we_q      <= pm_we_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.pm_we      = pm_we_q;
  assign bus.pm_addr    = pm_addr_q;
  assign bus.pm_wdata   = pm_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign load_done      = load_done_q;
  assign load_error     = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory
// writes and status snapshots into queues; a negedge monitor pops and
// compares them against what the loader presents.
module tb_program_loader;

  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic        chk_pm;
    logic        ready;
    logic        hold;
    logic        done;
    logic        err;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
  } st_t;

  logic clk;
  logic rst;
  logic load_req;
  logic cpu_hold;
  logic load_done;
  logic load_error;

  program_loader_if bus();

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .load_req   (load_req),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_t wr_q[$];
  st_t st_q[$];
  int  n_vec;
  int  n_err;
  int  tmo_cnt;
  int  tmo_seen;
  bit  fin_req;
  bit  fin_ack;

  // Monitor: compares writes, status snapshots and timeouts on each negedge.
  initial begin
    logic prev_we;
    wr_t  ew;
    st_t  es;
    n_vec    = 0;
    n_err    = 0;
    tmo_seen = 0;
    fin_ack  = 1'b0;
    prev_we  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pm_we === 1'b1) begin
        n_vec++;
        if (prev_we) begin
          n_err++;
          $display("FAIL we_pulse: pm_we high two cycles in a row at %0t, required one-cycle pulse", $time);
        end
        n_vec++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", bus.pm_addr, bus.pm_wdata);
        end else begin
          ew = wr_q.pop_front();
          if (bus.pm_addr !== ew.addr || bus.pm_wdata !== ew.data) begin
            n_err++;
            $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                     bus.pm_addr, bus.pm_wdata, ew.addr, ew.data);
          end
        end
      end
      prev_we = (bus.pm_we === 1'b1);
      if (st_q.size() != 0) begin
        es = st_q.pop_front();
        n_vec++;
        if (bus.byte_ready !== es.ready || cpu_hold !== es.hold || load_done !== es.done ||
            load_error !== es.err || bus.pm_we !== es.we ||
            (es.chk_pm && (bus.pm_addr !== es.addr || bus.pm_wdata !== es.data))) begin
          n_err++;
          $display("FAIL status at %0t: got rdy=%b hold=%b done=%b err=%b we=%b addr=%0d data=%h, required rdy=%b hold=%b done=%b err=%b we=%b addr=%0d data=%h (addr/data checked=%b)",
                   $time, bus.byte_ready, cpu_hold, load_done, load_error, bus.pm_we, bus.pm_addr, bus.pm_wdata,
                   es.ready, es.hold, es.done, es.err, es.we, es.addr, es.data, es.chk_pm);
        end
      end
      if (tmo_cnt != tmo_seen) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: byte not accepted within budget (%0d timeouts), required 0", tmo_cnt);
        tmo_seen = tmo_cnt;
      end
      if (fin_req && !fin_ack) begin
        n_vec++;
        if (wr_q.size() != 0 || st_q.size() != 0) begin
          n_err++;
          $display("FAIL drain: %0d writes and %0d status checks outstanding, required 0", wr_q.size(), st_q.size());
        end
        fin_ack = 1'b1;
      end
    end
  end

  task automatic exp_wr(input logic [4:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic exp_st(input logic ready, input logic hold, input logic done,
                        input logic err, input logic we);
    st_t s;
    s = '0;
    s.ready = ready;
    s.hold  = hold;
    s.done  = done;
    s.err   = err;
    s.we    = we;
    st_q.push_back(s);
  endtask

  task automatic exp_reset_st();
    st_t s;
    s = '0;
    s.chk_pm = 1'b1;
    s.ready  = 1'b1;
    s.hold   = 1'b1;
    st_q.push_back(s);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r;
    bit   ok;
    bus.byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      r = bus.byte_ready;
      @(posedge clk);
      if (r === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) tmo_cnt++;
  endtask

  task automatic stop_stream();
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    logic [7:0] cs;
    logic [7:0] hb;
    logic [7:0] lb;
    tmo_cnt        = 0;
    fin_req        = 1'b0;
    rst            = 1'b0;
    load_req       = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    exp_reset_st();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: two words, good checksum, valid held high.
    exp_wr(5'd0, 16'h1234);
    exp_wr(5'd1, 16'hABCD);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    begin
      st_t s;
      s = '0;
      s.chk_pm = 1'b1; s.ready = 1'b0; s.hold = 1'b1; s.we = 1'b1;
      s.addr = 5'd0; s.data = 16'h1234;
      st_q.push_back(s);
    end
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h42, 0);
    stop_stream();
    exp_st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_load_req();
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Frame 2: same data, bad checksum.
    exp_wr(5'd0, 16'h1234);
    exp_wr(5'd1, 16'hABCD);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h43, 0);
    stop_stream();
    exp_st(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_load_req();
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bad headers: zero and DEPTH+1.
    send_byte(8'h00, 0);
    stop_stream();
    exp_st(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_load_req();
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h21, 1);
    stop_stream();
    exp_st(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_load_req();
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Full 32-word image with random valid gaps.
    cs = 8'h20;
    send_byte(8'h20, $urandom_range(0, 2));
    for (int i = 0; i < 32; i++) begin
      hb = 8'(i * 7 + 3);
      lb = 8'(8'hA5 ^ 8'(i));
      cs = cs ^ hb ^ lb;
      exp_wr(5'(i), {hb, lb});
      send_byte(hb, $urandom_range(0, 3));
      send_byte(lb, $urandom_range(0, 3));
    end
    send_byte(cs, $urandom_range(0, 2));
    stop_stream();
    exp_st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_load_req();
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after the HI byte of word 1.
    exp_wr(5'd0, 16'h1122);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    stop_stream();
    rst = 1'b0;
    exp_reset_st();
    @(posedge clk);
    #1;
    exp_reset_st();
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    exp_wr(5'd0, 16'h0007);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h07, 0);
    send_byte(8'h06, 0);
    stop_stream();
    exp_st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_load_req();
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // load_req during HI is ignored; then restart from DONE and reload.
    exp_wr(5'd0, 16'h5566);
    exp_wr(5'd1, 16'h7788);
    send_byte(8'h02, 0);
    stop_stream();
    pulse_load_req();
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    send_byte(8'hCE, 0);
    stop_stream();
    exp_st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_load_req();
    exp_st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_wr(5'd0, 16'hBEEF);
    send_byte(8'h01, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_byte(8'h50, 0);
    stop_stream();
    exp_st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    fin_req = 1'b1;
    for (int i = 0; i < 20 && !fin_ack; i++) @(posedge clk);
    if (!fin_ack) $display("FAIL drain_ack: monitor did not complete final check");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, fin_ack ? n_err : n_err + 1);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image into the instruction memory from a byte stream, the write side of the instruction memory the CPU's program counter reads. Receives a framed stream (count header, instruction bytes, XOR checksum) over a valid/ready handshake and writes one 16-bit instruction per 5-bit address. Holds the CPU in reset until a complete, checksum-verified image has been written. Sits between the host byte interface and the instruction memory write port, beside the program counter.

## Interface
- DEPTH, 32, number of instruction slots (addresses 0..DEPTH-1); address width 5 for DEPTH=32
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-low
- byte_valid  input  1  byte_data holds a valid byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- load_req  input  1  restart request, honoured only in DONE or ERROR
- pm_we  output  1  instruction memory write enable, one-cycle pulse
- pm_addr  output  5  write address
- pm_wdata  output  16  instruction word
- cpu_hold  output  1  high holds the program counter and CPU in reset
- load_done  output  1  image loaded and verified
- load_error  output  1  bad header or checksum mismatch

## Operation
- Frame: header N (1..DEPTH), then N instructions of 2 bytes each, high byte first, then 1 checksum byte = XOR of header and all 2N instruction bytes.
- A byte transfers on a rising edge where byte_valid && byte_ready.
- States: IDLE, HI, LO, WRITE, CHECK, DONE, ERROR.
- IDLE: byte_ready=1. Header accepted: N==0 or N>DEPTH -> ERROR; else store N, addr=0, csum=header, -> HI.
- HI: byte_ready=1. Byte -> hi register, csum ^= byte, -> LO.
- LO: byte_ready=1. Byte -> lo register, csum ^= byte, -> WRITE.
- WRITE: byte_ready=0, pm_we=1, pm_addr=addr, pm_wdata={hi,lo}. Then addr==N-1 -> CHECK, else addr++ -> HI.
- CHECK: byte_ready=1. Byte==csum -> DONE, else -> ERROR.
- DONE: byte_ready=0, cpu_hold=0, load_done=1. load_req -> IDLE.
- ERROR: byte_ready=0, cpu_hold=1, load_error=1. load_req -> IDLE.
- load_req is ignored in IDLE, HI, LO, WRITE and CHECK.
- cpu_hold=1 in every state except DONE.
- byte_ready, pm_we, cpu_hold, load_done and load_error are registered state decodes with no combinational path from inputs.
- Reset values: state IDLE, byte_ready=1, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=1, load_done=0, load_error=0, internal count, addr and csum 0.

## Timing
- LO byte accepted at edge k: pm_we high for exactly the cycle after edge k, with addr and data stable in that cycle; byte_ready low in the same cycle.
- Throughput: 3 cycles per instruction at best (HI, LO, WRITE). The stream may stall any number of cycles in IDLE, HI, LO and CHECK without a state change.
- Checksum accepted at edge k: after edge k, load_done=1 and cpu_hold=0, or load_error=1.
- load_req at edge k in DONE: cpu_hold=1 and load_done=0 after edge k. The next header may transfer on edge k+1.
- Reset mid-load: the next cycle shows IDLE with reset values. Memory keeps any partial image, but cpu_hold=1 prevents it executing. No pm_we is issued during or after reset until a new LO byte.
- Address wrap cannot occur: N≤DEPTH bounds addr to DEPTH-1.

## Structure
- Package program_loader_pkg: state enum (IDLE, HI, LO, WRITE, CHECK, DONE, ERROR), BYTE_W=8, INSTR_W=16, PM_ADDR_W=5, PM_DEPTH=32.
- Single module with no sub-module. The checksum is a single 8-bit XOR register inside the FSM.
- pm_we/pm_addr/pm_wdata connect to a write port added to the instruction memory. cpu_hold is ORed into the program counter reset.

## Test plan
- Bytes 02,12,34,AB,CD,42 with byte_valid held high -> writes 0x1234@0 then 0xABCD@1, each pm_we one cycle; load_done=1 and cpu_hold=0 one edge after 0x42.
- Same frame with checksum 0x43 -> both writes occur; load_error=1, cpu_hold=1, load_done=0.
- Header 0x00 and, separately, header 0x21 -> ERROR after the header, no pm_we, byte_ready=0.
- Header 0x20 with 32 words and correct checksum, random byte_valid gaps -> 32 writes to addresses 0..31 in order with correct data, then DONE.
- rst asserted after the HI byte of word 1 -> outputs return to reset values; a fresh frame 01,00,07,06 loads 0x0007@0 and reaches DONE.
- load_req pulsed during HI (ignored, load continues), then in DONE -> IDLE, cpu_hold=1; a second frame loads correctly.
